// File: rtl/status_code_tx_if.sv
// Payload-in / code-byte-out handshake bundle for the status-code transmitter.
// slave is the transmitter's view; master is the view of the logic driving it.
interface status_code_tx_if;
  logic [15:0] pl_data;
  logic        pl_valid;
  logic        pl_ready;
  logic [7:0]  code;
  logic        code_valid;
  logic        code_last;
  logic        code_ready;

  modport slave (
    input  pl_data, pl_valid, code_ready,
    output pl_ready, code, code_valid, code_last
  );

  modport master (
    output pl_data, pl_valid, code_ready,
    input  pl_ready, code, code_valid, code_last
  );
endinterface

// File: rtl/status_code_tx.sv
// Serialises 16-bit status words into header/high/low[/xor] code frames; header valid 1 cycle after accept.
// A byte holds while code_ready is low; pl_ready is high only in IDLE, and every output is registered.
module status_code_tx #(
  parameter logic [3:0] HDR_TAG = 4'hA,
  parameter bit         CSUM_EN = 1'b1,
  parameter int         CNT_W   = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  status_code_tx_if.slave  bus,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [2:0] {IDLE, HEAD, HIGH, LOW, CSUM} state_t;

  state_t           state, state_nxt;
  logic [15:0]      pl_q, pl_nxt;
  logic [3:0]       seq, seq_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [7:0]       code_nxt;
  logic             vld_nxt, last_nxt;
  logic             hs, fin;
  logic [7:0]       hdr;

  assign hs  = bus.code_valid & bus.code_ready;
  assign hdr = {HDR_TAG, seq};

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state          <= IDLE;
      pl_q           <= '0;
      seq            <= '0;
      frame_cnt      <= '0;
      bus.code       <= 8'h00;
      bus.code_valid <= 1'b0;
      bus.code_last  <= 1'b0;
      bus.pl_ready   <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      pl_q           <= pl_nxt;
      seq            <= seq_nxt;
      frame_cnt      <= cnt_nxt;
      bus.code       <= code_nxt;
      bus.code_valid <= vld_nxt;
      bus.code_last  <= last_nxt;
      bus.pl_ready   <= (state_nxt == IDLE);
      busy           <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    pl_nxt    = pl_q;
    seq_nxt   = seq;
    cnt_nxt   = frame_cnt;
    code_nxt  = bus.code;
    vld_nxt   = bus.code_valid;
    last_nxt  = bus.code_last;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.pl_valid && bus.pl_ready) begin
          pl_nxt    = bus.pl_data;
          state_nxt = HEAD;
          code_nxt  = hdr;
          vld_nxt   = 1'b1;
          last_nxt  = 1'b0;
        end
      end
      HEAD: begin
        if (hs) begin
          state_nxt = HIGH;
          code_nxt  = pl_q[15:8];
        end
      end
      HIGH: begin
        if (hs) begin
          state_nxt = LOW;
          code_nxt  = pl_q[7:0];
          last_nxt  = !CSUM_EN;
        end
      end
      LOW: begin
        if (hs) begin
          if (CSUM_EN) begin
            state_nxt = CSUM;
            code_nxt  = hdr ^ pl_q[15:8] ^ pl_q[7:0];
            last_nxt  = 1'b1;
          end else begin
            fin = 1'b1;
          end
        end
      end
      CSUM: begin
        if (hs) fin = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    // Final byte accepted: close the frame and bump the header sequence.
    if (fin) begin
      state_nxt = IDLE;
      vld_nxt   = 1'b0;
      last_nxt  = 1'b0;
      seq_nxt   = seq + 4'd1;
      cnt_nxt   = frame_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_status_code_tx.sv
// Scoreboarded random/directed bench; lane 0 runs without checksum, lane 1 with checksum.
module tb_status_code_tx;

  logic clock, rst_n;
  logic bp_en, gap_en;
  int   tests = 0, fails = 0, cyc = 0;

  logic [1:0]  busy, m_vld, m_last, m_rdy;
  logic [15:0] fcnt [2];
  logic [7:0]  m_code [2];

  typedef struct packed {logic [7:0] b; logic l;} exp_t;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  function automatic void chk(string nm, int ln, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s lane%0d: got %h, expected %h", nm, ln, act, exp);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam bit CS = (g == 1);
    status_code_tx_if bus ();
    logic [15:0] src[$];
    exp_t        expq[$];
    int          nacc = 0, ndone = 0, last_acc = 0;
    logic        acc = 1'b0, b2b = 1'b0, last_seen = 1'b0, hold_pend = 1'b0;
    logic [7:0]  hold_code;
    logic        hold_last;

    status_code_tx #(.HDR_TAG(4'hA), .CSUM_EN(CS), .CNT_W(16)) dut (
      .clock(clock), .rst_n(rst_n), .bus(bus), .busy(busy[g]), .frame_cnt(fcnt[g])
    );

    assign m_vld[g]  = bus.code_valid;
    assign m_last[g] = bus.code_last;
    assign m_rdy[g]  = bus.pl_ready;
    assign m_code[g] = bus.code;

    // Reference: frame bytes from the header sequence = frames accepted since reset.
    function automatic void model(logic [15:0] w);
      logic [7:0] h;
      h = {4'hA, 4'(nacc % 16)};
      expq.push_back('{b: h, l: 1'b0});
      expq.push_back('{b: w[15:8], l: 1'b0});
      expq.push_back('{b: w[7:0], l: !CS});
      if (CS) expq.push_back('{b: h ^ w[15:8] ^ w[7:0], l: 1'b1});
      nacc++;
    endfunction

    initial begin
      bus.code_ready = 1'b1;
      forever begin
        @(posedge clock); #1;
        bus.code_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end

    initial begin
      bus.pl_valid = 1'b0;
      bus.pl_data  = 16'h0;
      forever begin
        @(negedge clock);
        if (acc && rst_n) chk("hdr_latency", g, bus.code_valid, 1);
        acc = rst_n && bus.pl_valid && bus.pl_ready;
        if (!rst_n) b2b = 1'b0;
        if (acc) begin
          if (b2b && !bp_en) chk("throughput", g, cyc - last_acc, CS ? 5 : 4);
          last_acc = cyc;
          model(bus.pl_data);
        end
        @(posedge clock); #1;
        if (acc && src.size() > 0) void'(src.pop_front());
        if (!bus.pl_valid || acc) begin
          if (src.size() > 0 && (!gap_en || $urandom_range(0, 1) == 1)) begin
            bus.pl_valid = 1'b1;
            bus.pl_data  = src[0];
            b2b          = acc;
          end else begin
            bus.pl_valid = 1'b0;
            b2b          = 1'b0;
          end
        end
      end
    end

    initial begin
      exp_t e;
      forever begin
        @(negedge clock);
        if (!rst_n) begin
          hold_pend = 1'b0;
          last_seen = 1'b0;
          continue;
        end
        chk("busy", g, busy[g], bus.code_valid);
        if (last_seen) begin
          chk("ready_after_last", g, bus.pl_ready, 1);
          chk("valid_drop", g, bus.code_valid, 0);
          chk("frame_cnt", g, fcnt[g], ndone);
        end
        last_seen = 1'b0;
        if (hold_pend)
          chk("bp_hold", g, {bus.code_valid, bus.code_last, bus.code}, {1'b1, hold_last, hold_code});
        hold_pend = bus.code_valid && !bus.code_ready;
        hold_code = bus.code;
        hold_last = bus.code_last;
        if (bus.code_valid && bus.code_ready) begin
          if (expq.size() == 0) begin
            chk("unexpected_byte", g, {bus.code_last, bus.code}, 9'h1ff);
          end else begin
            e = expq.pop_front();
            chk("code", g, bus.code, e.b);
            chk("code_last", g, bus.code_last, e.l);
          end
          if (bus.code_last) begin
            ndone++;
            last_seen = 1'b1;
          end
        end
      end
    end
  end

  task automatic push_both(logic [15:0] w);
    lane[0].src.push_back(w);
    lane[1].src.push_back(w);
  endtask

  task automatic wait_drain(string nm);
    int n = 0;
    while (n < 4000 && (lane[0].src.size() != 0 || lane[1].src.size() != 0 ||
           lane[0].expq.size() != 0 || lane[1].expq.size() != 0 || busy != 2'b00)) begin
      @(negedge clock);
      n++;
    end
    chk({nm, "_drained"}, 0, n < 4000, 1);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n  = 1'b0;
    bp_en  = 1'b0;
    gap_en = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk("rst_pl_ready", i, m_rdy[i], 0);
      chk("rst_code", i, m_code[i], 8'h00);
      chk("rst_code_valid", i, m_vld[i], 0);
      chk("rst_code_last", i, m_last[i], 0);
      chk("rst_busy", i, busy[i], 0);
      chk("rst_frame_cnt", i, fcnt[i], 0);
    end
    rst_n = 1'b1;
    @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 2; i++) chk("ready_after_release", i, m_rdy[i], 1);

    push_both(16'h1234);
    wait_drain("single");
    for (int i = 0; i < 2; i++) chk("cnt_single", i, fcnt[i], 1);

    bp_en = 1'b1;
    push_both(16'h1234);
    wait_drain("backpressure");

    bp_en = 1'b0;
    for (int k = 0; k < 17; k++) push_both(16'h0000);
    wait_drain("seq_wrap");

    push_both(16'h0001);
    push_both(16'h0002);
    wait_drain("b2b");

    bp_en  = 1'b1;
    gap_en = 1'b1;
    for (int k = 0; k < 40; k++) push_both(16'($urandom));
    wait_drain("random");
    for (int i = 0; i < 2; i++) chk("cnt_total", i, fcnt[i], 61);

    bp_en  = 1'b0;
    gap_en = 1'b0;
    push_both(16'h1234);
    n = 0;
    while (n < 200 && !(m_vld[1] && m_code[1] == 8'h34)) begin
      @(negedge clock);
      n++;
    end
    chk("rst_wait", 1, n < 200, 1);
    rst_n = 1'b0;
    @(posedge clock); #1;
    lane[0].expq.delete();
    lane[1].expq.delete();
    lane[0].nacc = 0;
    lane[1].nacc = 0;
    lane[0].ndone = 0;
    lane[1].ndone = 0;
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk("midrst_valid", i, m_vld[i], 0);
      chk("midrst_last", i, m_last[i], 0);
      chk("midrst_cnt", i, fcnt[i], 0);
    end
    rst_n = 1'b1;
    push_both(16'h5555);
    wait_drain("after_reset");
    for (int i = 0; i < 2; i++) chk("cnt_after_reset", i, fcnt[i], 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
